// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath.
// Signal names follow the controller's published port names.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic       pcUpdate;
    logic       irWrite;
    logic       regWrite;
    logic       memWrite;
    logic       branch;
    logic       adrSrc;
    logic [1:0] resSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] immSrc;
    logic       illegal;
    logic [3:0] state;

    modport master (
        output op,
        input  pcUpdate, irWrite, regWrite, memWrite, branch, adrSrc,
        input  resSrc, aluSrcA, aluSrcB, aluOp, immSrc, illegal, state
    );

    modport slave (
        input  op,
        output pcUpdate, irWrite, regWrite, memWrite, branch, adrSrc,
        output resSrc, aluSrcA, aluSrcB, aluOp, immSrc, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore-style main controller for a multicycle RISC-V core.
// FETCH and MEMREAD stretch by MEM_WAIT cycles using a 4-bit wait counter.
module multicycle_ctrl #(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned TRAP_EN  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_ctrl_if.slave      bus
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10,
        StTrap     = 4'd11
    } state_e;

    localparam logic [6:0] OpLw   = 7'd3;
    localparam logic [6:0] OpSw   = 7'd35;
    localparam logic [6:0] OpR    = 7'd51;
    localparam logic [6:0] OpI    = 7'd19;
    localparam logic [6:0] OpBeq  = 7'd99;
    localparam logic [6:0] OpJal  = 7'd111;
    localparam logic [3:0] WaitLast = 4'(MEM_WAIT);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       wait_done;

    assign wait_done = (cnt_q == WaitLast);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:    if (wait_done) state_d = StDecode;
            StDecode: begin
                unique case (bus.op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpR:        state_d = StExecR;
                    OpI:        state_d = StExecI;
                    OpBeq:      state_d = StBeq;
                    OpJal:      state_d = StJal;
                    default:    state_d = (TRAP_EN != 0) ? StTrap : StFetch;
                endcase
            end
            StMemAdr:   state_d = (bus.op == OpLw) ? StMemRead : StMemWrite;
            StMemRead:  if (wait_done) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StJal:      state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBeq:      state_d = StFetch;
            StTrap:     state_d = StTrap;
            default:    state_d = StFetch;
        endcase
    end

    // Counter only runs while lingering in a wait state; any state change clears it.
    always_comb begin
        cnt_d = 4'd0;
        if ((state_q == StFetch || state_q == StMemRead) && state_d == state_q) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_comb begin
        bus.pcUpdate = 1'b0;
        bus.irWrite  = 1'b0;
        bus.regWrite = 1'b0;
        bus.memWrite = 1'b0;
        bus.branch   = 1'b0;
        bus.adrSrc   = 1'b0;
        bus.resSrc   = 2'b00;
        bus.aluSrcA  = 2'b00;
        bus.aluSrcB  = 2'b00;
        bus.aluOp    = 2'b00;
        bus.illegal  = 1'b0;
        unique case (state_q)
            StFetch: begin
                bus.aluSrcB  = 2'b10;
                bus.resSrc   = 2'b10;
                // Reset holds the register in FETCH; keep its final-cycle strobes quiet.
                bus.irWrite  = wait_done & ~reset;
                bus.pcUpdate = wait_done & ~reset;
            end
            StDecode: begin
                bus.aluSrcA = 2'b01;
                bus.aluSrcB = 2'b01;
            end
            StMemAdr: begin
                bus.aluSrcA = 2'b10;
                bus.aluSrcB = 2'b01;
            end
            StMemRead:  bus.adrSrc = 1'b1;
            StMemWb: begin
                bus.resSrc   = 2'b01;
                bus.regWrite = 1'b1;
            end
            StMemWrite: begin
                bus.adrSrc   = 1'b1;
                bus.memWrite = 1'b1;
            end
            StExecR: begin
                bus.aluSrcA = 2'b10;
                bus.aluOp   = 2'b10;
            end
            StExecI: begin
                bus.aluSrcA = 2'b10;
                bus.aluSrcB = 2'b01;
                bus.aluOp   = 2'b10;
            end
            StAluWb:    bus.regWrite = 1'b1;
            StBeq: begin
                bus.aluSrcA = 2'b10;
                bus.aluOp   = 2'b01;
                bus.branch  = 1'b1;
            end
            StJal: begin
                bus.aluSrcA  = 2'b01;
                bus.aluSrcB  = 2'b10;
                bus.pcUpdate = 1'b1;
            end
            StTrap:     bus.illegal = 1'b1;
            default:    ;
        endcase
    end

    always_comb begin
        unique case (bus.op)
            OpSw:    bus.immSrc = 2'b01;
            OpBeq:   bus.immSrc = 2'b10;
            OpJal:   bus.immSrc = 2'b11;
            default: bus.immSrc = 2'b00;
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_WAIT, default 0, extra memory wait cycles per fetch/load access, legal range 0..15.
REQ-002 Parameter TRAP_EN, default 1, 1 = an unsupported opcode enters TRAP; 0 = an unsupported opcode returns to FETCH.
REQ-003 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 op  input  7  opcode from the instruction register, sampled only in DECODE.
REQ-006 pcUpdate, irWrite, regWrite, memWrite, branch  output  1 each  write/enable strobes.
REQ-007 adrSrc  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-008 resSrc, aluSrcA, aluSrcB, aluOp  output  2 each  result mux, ALU A mux, ALU B mux, ALU operation class.
REQ-009 immSrc  output  2  immediate format, combinational from op.
REQ-010 illegal  output  1  high while in TRAP.
REQ-011 state  output  4  current state code, for debug.

Function
REQ-012 The block SHALL be a Moore FSM: every output except immSrc is decoded from the state register and the wait counter only.
REQ-013 State codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
REQ-014 Any output not listed for a state SHALL be 0.
REQ-015 FETCH outputs SHALL be: adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resSrc=10.
REQ-016 irWrite and pcUpdate SHALL be 1 only in the final FETCH cycle.
REQ-017 DECODE outputs SHALL be: aluSrcA=01, aluSrcB=01, aluOp=00.
REQ-018 MEMADR outputs SHALL be: aluSrcA=10, aluSrcB=01, aluOp=00.
REQ-019 MEMREAD outputs SHALL be: adrSrc=1, resSrc=00.
REQ-020 MEMWB outputs SHALL be: resSrc=01, regWrite=1.
REQ-021 MEMWRITE outputs SHALL be: adrSrc=1, memWrite=1, asserted for exactly one cycle.
REQ-022 EXECR outputs SHALL be: aluSrcA=10, aluSrcB=00, aluOp=10.
REQ-023 EXECI outputs SHALL be: aluSrcA=10, aluSrcB=01, aluOp=10.
REQ-024 ALUWB outputs SHALL be: resSrc=00, regWrite=1.
REQ-025 BEQ outputs SHALL be: aluSrcA=10, aluSrcB=00, aluOp=01, resSrc=00, branch=1.
REQ-026 JAL outputs SHALL be: aluSrcA=01, aluSrcB=10, aluOp=00, resSrc=00, pcUpdate=1.
REQ-027 TRAP outputs SHALL be: illegal=1; all strobes 0.
REQ-028 FETCH and MEMREAD SHALL each last MEM_WAIT+1 cycles, timed by a 4-bit wait counter that is cleared on entry and increments each cycle in these states.
REQ-029 Exit from FETCH or MEMREAD SHALL occur when the wait counter equals MEM_WAIT.
REQ-030 Transitions: FETCH->DECODE.
REQ-031 Transitions from DECODE by op: 3 or 35 -> MEMADR; 51 -> EXECR; 19 -> EXECI; 99 -> BEQ; 111 -> JAL.
REQ-032 Any other op in DECODE SHALL go to TRAP if TRAP_EN=1, else to FETCH with no strobe asserted.
REQ-033 Transitions: MEMADR -> MEMREAD if op=3, else MEMWRITE.
REQ-034 Transitions: MEMREAD->MEMWB; MEMWB->FETCH; MEMWRITE->FETCH.
REQ-035 Transitions: EXECR->ALUWB; EXECI->ALUWB; JAL->ALUWB; ALUWB->FETCH; BEQ->FETCH.
REQ-036 TRAP SHALL be absorbing until reset.
REQ-037 Total cycle counts with W=MEM_WAIT: lw 5+2W, sw 4+W, R-type/I-type/jal 4+W, beq 3+W.
REQ-038 immSrc SHALL be: op 3 or 19 -> 00; 35 -> 01; 99 -> 10; 111 -> 11; otherwise 00.
REQ-039 op SHALL be ignored in all states other than DECODE and MEMADR.

Reset
REQ-040 Asserting reset SHALL asynchronously force state=FETCH and wait counter=0, including mid-instruction.
REQ-041 While reset is high, pcUpdate, irWrite, regWrite, memWrite, branch and illegal SHALL be 0; the mux selects SHALL show the FETCH values.
REQ-042 The first cycle after reset deasserts SHALL be the first FETCH cycle.

Verification
REQ-043 MEM_WAIT=0, op=51: states 0,1,6,8,0; regWrite=1 only in cycle 4; irWrite=pcUpdate=1 in cycle 1.
REQ-044 MEM_WAIT=2, op=3: FETCH lasts 3 cycles with irWrite only in the 3rd; MEMREAD lasts 3 cycles; total 9 cycles; MEMWB resSrc=01.
REQ-045 MEM_WAIT=0, op=35: memWrite=1 for exactly one cycle in state 5; immSrc=01; regWrite never asserted.
REQ-046 MEM_WAIT=0, op=99 then op=111: beq takes 3 cycles with branch=1 in BEQ; jal takes 4 cycles with pcUpdate=1 in JAL, then regWrite=1 in ALUWB.
REQ-047 op=0x7F in DECODE: with TRAP_EN=1, state=11 and illegal=1 held for 10+ cycles; with TRAP_EN=0, returns to FETCH with no strobes asserted.
REQ-048 Reset pulse asserted in MEMWRITE between clock edges: memWrite drops immediately; state=0; after release, normal fetch resumes.
